// File: rtl/sprite_print_engine.sv
// rtl/sprite_print_engine.sv - per-pixel sprite/background lookup and memory address issue engine
module sprite_print_engine #(
  parameter int          SIZE_X    = 10,
  parameter int          SIZE_Y    = 9,
  parameter int          SIZE_ADDR = 17,
  parameter int          SPRITE_W  = 20,
  parameter int          SCREEN_W  = 480,
  parameter int          SCREEN_H  = 320,
  parameter int          BG_ADDR   = 115200,
  parameter logic [31:0] BG_CODE   = 32'h00000001,
  parameter int          TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     active_area,
  input  logic [SIZE_X-1:0]        pixel_x,
  input  logic [SIZE_Y-1:0]        pixel_y,
  input  logic                     data_valid,
  input  logic [31:0]              data_reg,
  output logic                     check_valid,
  output logic [SIZE_X+SIZE_Y-1:0] check_value,
  output logic                     mem_req,
  output logic [SIZE_ADDR-1:0]     memory_address,
  output logic                     sprite_on,
  output logic [31:0]              sprite_datas,
  output logic                     printing_screen,
  output logic                     err_timeout
);

  localparam logic [SIZE_X-1:0]    SCR_W_X  = SIZE_X'(SCREEN_W);
  localparam logic [SIZE_Y-1:0]    SCR_H_Y  = SIZE_Y'(SCREEN_H);
  localparam logic [SIZE_ADDR-1:0] BG_A     = SIZE_ADDR'(BG_ADDR);
  localparam logic [15:0]          SCR_W_16 = 16'(SCREEN_W);
  localparam logic [15:0]          SPR_W_16 = 16'(SPRITE_W);
  localparam logic [7:0]           TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    QUERY  = 3'd1,
    WAIT   = 3'd2,
    BG     = 3'd3,
    SPRITE = 3'd4
  } state_t;

  state_t                state;
  logic                  ready;       // blocks a query on the first edge after reset release
  logic [7:0]            wait_cnt;
  logic [7:0]            offset;      // offset of the address currently on memory_address
  logic [SIZE_X-1:0]     cap_x;       // x captured at query, drives line clipping
  logic [15:0]           remaining;
  logic [15:0]           sprite_len;
  logic                  last_issue;
  logic [SIZE_ADDR-1:0]  next_addr;

  // Clipped line length: pixels left to the right screen edge, capped at the sprite width
  always_comb begin
    remaining  = '0;
    sprite_len = '0;
    if (16'(cap_x) < SCR_W_16) begin
      remaining  = SCR_W_16 - 16'(cap_x);
      sprite_len = (remaining < SPR_W_16) ? remaining : SPR_W_16;
    end
    last_issue = (16'(offset) + 16'd1) >= sprite_len;
    next_addr  = sprite_datas[SIZE_ADDR-1:0] + SIZE_ADDR'(offset + 8'd1);
  end

  // Registered on-screen flag for the current pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      printing_screen <= 1'b0;
    end else begin
      printing_screen <= active_area && (pixel_x < SCR_W_X) && (pixel_y < SCR_H_Y);
    end
  end

  // Query / wait / issue state machine with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ready          <= 1'b0;
      wait_cnt       <= '0;
      offset         <= '0;
      cap_x          <= '0;
      check_valid    <= 1'b0;
      check_value    <= '0;
      mem_req        <= 1'b0;
      memory_address <= '0;
      sprite_on      <= 1'b0;
      sprite_datas   <= '0;
      err_timeout    <= 1'b0;
    end else begin
      ready <= 1'b1;
      case (state)
        IDLE: begin
          check_valid    <= 1'b0;
          mem_req        <= 1'b0;
          memory_address <= '0;
          sprite_on      <= 1'b0;
          if (ready && active_area) begin
            state       <= QUERY;
            check_valid <= 1'b1;
            check_value <= {pixel_x, pixel_y};
            cap_x       <= pixel_x;
          end
        end
        QUERY: begin
          check_valid <= 1'b0;
          check_value <= '0;
          wait_cnt    <= '0;
          state       <= active_area ? WAIT : IDLE;
        end
        WAIT: begin
          if (!active_area) begin
            state <= IDLE;
          end else if (data_valid) begin
            if ((data_reg == BG_CODE) || !data_reg[31]) begin
              state          <= BG;
              mem_req        <= 1'b1;
              memory_address <= BG_A;
            end else begin
              sprite_datas <= data_reg;
              offset       <= '0;
              if (sprite_len != '0) begin
                state          <= SPRITE;
                mem_req        <= 1'b1;
                sprite_on      <= 1'b1;
                memory_address <= data_reg[SIZE_ADDR-1:0];
              end else begin
                // x already past the right edge: nothing to draw on this line
                state <= IDLE;
              end
            end
          end else if (wait_cnt == TO_LAST) begin
            state          <= BG;
            mem_req        <= 1'b1;
            memory_address <= BG_A;
            err_timeout    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        BG: begin
          state          <= IDLE;
          mem_req        <= 1'b0;
          memory_address <= '0;
        end
        SPRITE: begin
          if (!active_area || last_issue) begin
            state          <= IDLE;
            mem_req        <= 1'b0;
            sprite_on      <= 1'b0;
            memory_address <= '0;
          end else begin
            offset         <= offset + 8'd1;
            memory_address <= next_addr;
          end
        end
        default: begin
          state          <= IDLE;
          check_valid    <= 1'b0;
          mem_req        <= 1'b0;
          memory_address <= '0;
          sprite_on      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sprite_print_engine.md
SPRITE_PRINT_ENGINE -- requirements
Module: sprite_print_engine

Interface
REQ-001 SHALL have parameter SIZE_X, default 10, pixel_x width.
REQ-002 SHALL have parameter SIZE_Y, default 9, pixel_y width.
REQ-003 SHALL have parameter SIZE_ADDR, default 17, memory address width.
REQ-004 SHALL have parameter SPRITE_W, default 20, pixels per sprite line, range 1..255.
REQ-005 SHALL have parameters SCREEN_W = 480 and SCREEN_H = 320, the printable area.
REQ-006 SHALL have parameter BG_ADDR, default 115200, background colour address.
REQ-007 SHALL have parameter BG_CODE, default 32'h00000001, the register-bank code for "background".
REQ-008 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles to wait for data_valid.
REQ-009 Ports, one clock and one reset; reset is asynchronous and active-low:
  clk  in  1  sole clock; all logic on rising edge
  reset  in  1  asynchronous active-low reset
  active_area  in  1  VGA active-area flag
  pixel_x  in  SIZE_X  current x coordinate
  pixel_y  in  SIZE_Y  current y coordinate
  data_valid  in  1  register-bank response strobe
  data_reg  in  32  register-bank word; [31] visible, [SIZE_ADDR-1:0] sprite line base address
  check_valid  out  1  one-cycle query strobe
  check_value  out  SIZE_X+SIZE_Y  {pixel_x, pixel_y}, captured at query
  mem_req  out  1  memory read strobe
  memory_address  out  SIZE_ADDR  read address, valid when mem_req = 1
  sprite_on  out  1  high while sprite addresses are being issued
  sprite_datas  out  32  data_reg latched on sprite acceptance
  printing_screen  out  1  registered in-screen flag
  err_timeout  out  1  sticky timeout flag

Function
REQ-010 SHALL implement the states IDLE, QUERY, WAIT, BG and SPRITE.
REQ-011 IDLE: if active_area = 1, go to QUERY; otherwise stay in IDLE.
REQ-012 QUERY lasts one cycle:
  - check_valid = 1;
  - check_value = {pixel_x, pixel_y} sampled in this cycle;
  - go to WAIT, with the wait counter cleared.
REQ-013 WAIT: data_valid is the only exit condition other than timeout and abort (REQ-017, REQ-018):
  - data_valid = 1 and (data_reg = BG_CODE or data_reg[31] = 0): go to BG;
  - data_valid = 1 otherwise: go to SPRITE, latch sprite_datas, load the offset counter with 0.
REQ-014 BG lasts one cycle: mem_req = 1, memory_address = BG_ADDR, then go to IDLE.
REQ-015 SPRITE: each cycle issue mem_req = 1 with memory_address = base + offset, with sprite_on = 1.
  - The sum wraps modulo 2^SIZE_ADDR; no carry out.
  - The offset increments by 1 each cycle.
REQ-016 The SPRITE line length SHALL be clipped:
  - N = min(SPRITE_W, SCREEN_W - captured x);
  - the captured x is the value from check_value;
  - after the issue with offset N-1, go to IDLE; sprite_on falls in the same cycle.
REQ-017 Timeout: WAIT for TIMEOUT cycles without data_valid SHALL do the following:
  - treat the result as background and go to BG;
  - set err_timeout, which stays 1 until reset.
REQ-018 Abort: active_area = 0 in QUERY, WAIT or SPRITE SHALL do the following:
  - go to IDLE on the next edge;
  - issue no further mem_req;
  - deassert sprite_on.
REQ-019 Simultaneous events SHALL be resolved by priority: abort > data_valid > timeout.
REQ-020 data_valid asserted outside WAIT SHALL be ignored.
REQ-021 printing_screen SHALL be registered each cycle as active_area AND pixel_x < SCREEN_W AND pixel_y < SCREEN_H.
REQ-022 No output SHALL ever carry X; unused address and data values SHALL be 0.
REQ-023 Latency, one cycle per clock edge:
  - active_area rising to check_valid: 1 cycle;
  - data_valid to first mem_req: 1 cycle.

Reset
REQ-024 While reset = 0, the block SHALL be in state IDLE.
REQ-025 While reset = 0, every output SHALL be 0; err_timeout SHALL be cleared.
REQ-026 While reset = 0, all internal counters SHALL be cleared.
REQ-027 Reset asserted mid-sprite SHALL drop mem_req and sprite_on immediately (asynchronously).
REQ-028 After reset releases, the first query SHALL occur no earlier than the second rising edge.

Verification
REQ-029 Background pixel: active_area = 1, x = 100, y = 50; data_valid with data_reg = 32'h1 two cycles after check_valid -> check_value = {100, 50}; one mem_req at 115200; back to IDLE.
REQ-030 Full sprite: x = 0; data_reg = 32'h8000_0400 -> 20 consecutive mem_req at addresses 1024..1043; sprite_on high for exactly 20 cycles; sprite_datas = 32'h8000_0400.
REQ-031 Clipping: x = 470, SPRITE_W = 20 -> exactly 10 mem_req at base..base+9.
REQ-032 Wrap-around: base = 17'h1FFFE -> addresses 1FFFE, 1FFFF, 00000, ... with no X on any output.
REQ-033 Timeout: no data_valid for 15 cycles -> one mem_req at BG_ADDR; err_timeout = 1 and held; a late data_valid is ignored.
REQ-034 Abort and reset: active_area drops on offset 5 -> mem_req low on the next cycle; reset pulsed mid-sprite -> all outputs 0 at once; printing_screen = 0 for y = 320.
